control_estacionamiento: RTL and testbench
==========================================

CONTROL_ESTACIONAMIENTO -- requirements
Module: control_estacionamiento

Interface
REQ-001 Parameter CAPACIDAD, default 7, maximum vehicles admitted.
REQ-002 Parameter ANCHO, default 7, width of occupancy outputs; SHALL satisfy 2^ANCHO > CAPACIDAD.
REQ-003 Parameter DEBOUNCE, default 4, consecutive stable cycles (>=1) before a sensor level is accepted.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-006 entrada  input  1  raw entry-gate vehicle sensor, asynchronous level, 1 = vehicle present.
REQ-007 salida  input  1  raw exit-gate vehicle sensor, asynchronous level, 1 = vehicle present.
REQ-008 espacio  output  ANCHO  vehicles currently inside.
REQ-009 libres  output  ANCHO  free places, CAPACIDAD - espacio.
REQ-010 lleno  output  1  1 when espacio == CAPACIDAD.
REQ-011 vacio  output  1  1 when espacio == 0.
REQ-012 barrera_entrada  output  1  entry barrier open command.
REQ-013 barrera_salida  output  1  exit barrier open command.
REQ-014 rechazos  output  8  entries refused while full, saturating.
REQ-015 error  output  1  sticky flag: exit event while empty.

Function
REQ-016 Each sensor SHALL pass through a 2-flop synchronizer, then a debounce filter.
REQ-017 Filter: counter increments each edge the synchronized level differs from the filtered level; resets to 0 on any cycle they agree; filtered level toggles on the edge the count reaches DEBOUNCE.
REQ-018 Event = filtered level 1 while its registered previous value is 0; one event per accepted rising level, none on falling.
REQ-019 Latency: if edge k is the first edge sampling a raw 1 that stays high, espacio/barrier respond at edge k+DEBOUNCE+2 (k+6 at default).
REQ-020 Raw pulses or glitches shorter than DEBOUNCE synchronized cycles SHALL produce no event.
REQ-021 Entry event only, not lleno: espacio+1, barrera_entrada set.
REQ-022 Entry event only, lleno: espacio unchanged, barrera_entrada stays 0, rechazos+1 saturating at 255.
REQ-023 Exit event only, not vacio: espacio-1, barrera_salida set.
REQ-024 Exit event only, vacio: espacio unchanged, barrera_salida stays 0, error set to 1 until reset.
REQ-025 Simultaneous entry and exit events: espacio unchanged, both barriers set, no rechazo, even when lleno or vacio.
REQ-026 Per-gate barrier FSM states CERRADA/ABIERTA: CERRADA->ABIERTA on accepted event; ABIERTA->CERRADA on the edge the filtered sensor falls; further events impossible while ABIERTA.
REQ-027 Barrier outputs are registered, equal to 1 exactly in state ABIERTA.
REQ-028 espacio SHALL never exceed CAPACIDAD nor wrap below 0; libres, lleno, vacio derived combinationally from espacio.

Reset
REQ-029 reset = 0 SHALL asynchronously force espacio=0, libres=CAPACIDAD, vacio=1, lleno=0, barriers=0/CERRADA, rechazos=0, error=0, synchronizers, filters and debounce counters = 0.
REQ-030 Reset asserted mid-operation (barrier open, debounce in progress) SHALL abandon it; a sensor still high after release is accepted as a new event after full latency.
REQ-031 Reset release is synchronized internally; state first changes no earlier than the second rising edge after release.

Verification
REQ-032 Defaults, entrada high 10 cycles then low, x3 -> espacio 1,2,3; each update at edge k+6; barrera_entrada high from update until filtered fall.
REQ-033 entrada glitch high 3 cycles (DEBOUNCE=4) -> espacio, barriers unchanged.
REQ-034 Fill to 7 then 2 more entries -> espacio=7, lleno=1, libres=0, barrera_entrada stays 0, rechazos=2.
REQ-035 From 0, one salida event -> espacio=0, error=1, remains 1 after later valid entries.
REQ-036 espacio=7, entrada and salida raised same cycle -> espacio=7, both barriers 1, rechazos unchanged.
REQ-037 Reset low while barrera_entrada=1 and espacio=5 -> all outputs to reset values same cycle; entrada held high -> espacio=1 after release plus latency.

Source files
------------

// File: rtl/control_estacionamiento.sv
// Parking-lot controller: counts vehicles through an entry and an exit gate,
// drives one barrier per gate and flags refused entries and spurious exits.
// Each raw sensor goes through a 2-flop synchronizer and a debounce filter,
// and a rising edge of the filtered level is one event.
module control_estacionamiento #(
    parameter int CAPACIDAD = 7,
    parameter int ANCHO     = 7,
    parameter int DEBOUNCE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entrada,
    input  logic             salida,
    output logic [ANCHO-1:0] espacio,
    output logic [ANCHO-1:0] libres,
    output logic             lleno,
    output logic             vacio,
    output logic             barrera_entrada,
    output logic             barrera_salida,
    output logic [7:0]       rechazos,
    output logic             error
);

    // The debounce counter only has to hold DEBOUNCE-1. When it would reach
    // DEBOUNCE, the filtered level toggles and the counter restarts at zero.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [ANCHO-1:0] CAP   = ANCHO'(CAPACIDAD);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE - 1);

    typedef enum logic {CERRADA = 1'b0, ABIERTA = 1'b1} estado_t;

    // Index 0 is the entry gate and index 1 is the exit gate.
    logic [1:0]      rst_sync_q;
    logic            run;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d, filt_prev_q;
    logic [CW-1:0]   cnt_q [2];
    logic [CW-1:0]   cnt_d [2];
    logic [1:0]      ev;
    logic [1:0]      abre;
    logic [ANCHO-1:0] esp_q, esp_d;
    logic [7:0]      rech_q, rech_d;
    logic            err_q, err_d;
    estado_t         est_q [2];
    estado_t         est_d [2];
    logic [1:0]      bar_d, bar_q;

    // Reset release is synchronized. The sensor path stays frozen until the
    // release has passed through both flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign run = rst_sync_q[1];

    // Two-flop synchronizers for the asynchronous gate sensors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else if (run) begin
            sync1_q <= {salida, entrada};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive disagreements and accept the new level on the DEBOUNCE-th one.
    always_comb begin
        filt_d = filt_q;
        for (int g = 0; g < 2; g++) begin
            cnt_d[g] = '0;
            if (sync2_q[g] != filt_q[g]) begin
                if (cnt_q[g] == CNT_MAX) filt_d[g] = sync2_q[g];
                else                     cnt_d[g]  = cnt_q[g] + 1'b1;
            end
        end
    end

    // Filter state plus the previous filtered level used for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q      <= 2'b00;
            filt_prev_q <= 2'b00;
            for (int g = 0; g < 2; g++) cnt_q[g] <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            for (int g = 0; g < 2; g++) cnt_q[g] <= cnt_d[g];
        end
    end

    assign ev = filt_q & ~filt_prev_q;

    assign lleno = (esp_q == CAP);
    assign vacio = (esp_q == '0);

    // A simultaneous entry and exit always opens both gates, even at the limits.
    assign abre[0] = ev[0] & (ev[1] | ~lleno);
    assign abre[1] = ev[1] & (ev[0] | ~vacio);

    // Occupancy, rejection count and error flag updates.
    always_comb begin
        esp_d  = esp_q;
        rech_d = rech_q;
        err_d  = err_q;
        if (ev[0] && !ev[1]) begin
            if (!lleno)                esp_d  = esp_q + 1'b1;
            else if (rech_q != 8'hFF)  rech_d = rech_q + 1'b1;
        end else if (ev[1] && !ev[0]) begin
            if (!vacio) esp_d = esp_q - 1'b1;
            else        err_d = 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            esp_q  <= '0;
            rech_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            esp_q  <= esp_d;
            rech_q <= rech_d;
            err_q  <= err_d;
        end
    end

    // Barrier FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < 2; g++) est_q[g] <= CERRADA;
        end else begin
            for (int g = 0; g < 2; g++) est_q[g] <= est_d[g];
        end
    end

    // Barrier next state: open on an accepted event, close on the edge the filtered sensor falls.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            est_d[g] = est_q[g];
            case (est_q[g])
                CERRADA: if (abre[g])    est_d[g] = ABIERTA;
                ABIERTA: if (!filt_d[g]) est_d[g] = CERRADA;
                default:                 est_d[g] = CERRADA;
            endcase
        end
    end

    // Barrier output decode from the next state.
    always_comb begin
        bar_d = 2'b00;
        for (int g = 0; g < 2; g++) bar_d[g] = (est_d[g] == ABIERTA);
    end

    // Registered barrier commands, which track the FSM state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bar_q <= 2'b00;
        else        bar_q <= bar_d;
    end

    assign espacio         = esp_q;
    assign libres          = CAP - esp_q;
    assign barrera_entrada = bar_q[0];
    assign barrera_salida  = bar_q[1];
    assign rechazos        = rech_q;
    assign error           = err_q;

endmodule

// File: tb/tb_control_estacionamiento.sv
// Directed testbench for control_estacionamiento at default parameters.
module tb_control_estacionamiento;

    logic       clk;
    logic       reset;
    logic       entrada;
    logic       salida;
    logic [6:0] espacio;
    logic [6:0] libres;
    logic       lleno;
    logic       vacio;
    logic       barrera_entrada;
    logic       barrera_salida;
    logic [7:0] rechazos;
    logic       error;

    int checks   = 0;
    int failures = 0;
    logic seen_be, seen_bs;

    control_estacionamiento dut (
        .clk             (clk),
        .reset           (reset),
        .entrada         (entrada),
        .salida          (salida),
        .espacio         (espacio),
        .libres          (libres),
        .lleno           (lleno),
        .vacio           (vacio),
        .barrera_entrada (barrera_entrada),
        .barrera_salida  (barrera_salida),
        .rechazos        (rechazos),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        seen_be = seen_be | barrera_entrada;
        seen_bs = seen_bs | barrera_salida;
    endtask

    // Hold the chosen sensors high for 'hi' sampled edges, then let everything settle.
    task automatic car(input logic e, input logic s, input int hi);
        seen_be = 1'b0;
        seen_bs = 1'b0;
        entrada = e;
        salida  = s;
        repeat (hi) tick();
        entrada = 1'b0;
        salida  = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_be;
        reset   = 1'b0;
        entrada = 1'b0;
        salida  = 1'b0;
        seen_be = 1'b0;
        seen_bs = 1'b0;
        repeat (3) tick();
        chk("rst_espacio", espacio, 0);
        chk("rst_libres", libres, 7);
        chk("rst_vacio", vacio, 1);
        chk("rst_lleno", lleno, 0);
        chk("rst_be", barrera_entrada, 0);
        chk("rst_bs", barrera_salida, 0);
        chk("rst_rechazos", rechazos, 0);
        chk("rst_error", error, 0);
        reset = 1'b1;
        repeat (4) tick();

        // First entry: the update lands on edge k+6 and the barrier closes on edge k+15.
        entrada = 1'b1;
        repeat (6) tick();
        chk("lat_before", espacio, 0);
        tick();
        chk("lat_update", espacio, 1);
        chk("lat_be_open", barrera_entrada, 1);
        repeat (3) tick();
        entrada = 1'b0;
        repeat (5) tick();
        chk("be_hold", barrera_entrada, 1);
        tick();
        chk("be_close", barrera_entrada, 0);
        repeat (8) tick();

        car(1'b1, 1'b0, 10);
        chk("entry2", espacio, 2);
        car(1'b1, 1'b0, 10);
        chk("entry3", espacio, 3);
        chk("entry3_libres", libres, 4);
        chk("entry3_be", seen_be, 1);

        // A 3-cycle glitch is filtered out; a 4-cycle pulse is accepted.
        car(1'b1, 1'b0, 3);
        chk("glitch_espacio", espacio, 3);
        chk("glitch_be", seen_be, 0);
        car(1'b1, 1'b0, 4);
        chk("min_pulse", espacio, 4);

        repeat (3) car(1'b1, 1'b0, 10);
        chk("full_espacio", espacio, 7);
        chk("full_lleno", lleno, 1);
        chk("full_libres", libres, 0);
        chk("full_vacio", vacio, 0);

        any_be = 1'b0;
        car(1'b1, 1'b0, 10);
        any_be = any_be | seen_be;
        car(1'b1, 1'b0, 10);
        any_be = any_be | seen_be;
        chk("rej_espacio", espacio, 7);
        chk("rej_be", any_be, 0);
        chk("rej_count", rechazos, 2);

        // 254 more refusals take the count past 255, where it saturates.
        for (int i = 0; i < 254; i++) car(1'b1, 1'b0, 6);
        chk("rej_saturate", rechazos, 255);

        car(1'b1, 1'b1, 10);
        chk("simul_espacio", espacio, 7);
        chk("simul_be", seen_be, 1);
        chk("simul_bs", seen_bs, 1);
        chk("simul_rechazos", rechazos, 255);

        repeat (3) car(1'b0, 1'b1, 10);
        chk("exit_espacio", espacio, 4);
        chk("exit_bs", seen_bs, 1);
        chk("exit_error", error, 0);

        // Reset while the entry barrier is open and entrada stays high.
        entrada = 1'b1;
        repeat (7) tick();
        chk("mid_espacio", espacio, 5);
        chk("mid_be", barrera_entrada, 1);
        reset = 1'b0;
        #1;
        chk("async_espacio", espacio, 0);
        chk("async_libres", libres, 7);
        chk("async_vacio", vacio, 1);
        chk("async_be", barrera_entrada, 0);
        chk("async_rechazos", rechazos, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        chk("rel_before", espacio, 0);
        tick();
        chk("rel_update", espacio, 1);
        chk("rel_be", barrera_entrada, 1);
        entrada = 1'b0;
        repeat (12) tick();

        // An exit while empty sets the sticky error flag.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (4) tick();
        car(1'b0, 1'b1, 10);
        chk("err_espacio", espacio, 0);
        chk("err_flag", error, 1);
        chk("err_bs", seen_bs, 0);
        car(1'b1, 1'b0, 10);
        chk("err_after_entry", espacio, 1);
        chk("err_sticky", error, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
